dcache: RTL
===========

# dcache

Direct-mapped, write-through, no-write-allocate data cache. It is the responder end of `dcache_if` and serves the control unit's MEMORY-state loads and stores. Load misses refill a whole line from a word-wide backing-memory port. Stores are written through to memory, and the line is also updated if it is resident. Load data is extracted per `size`/`sign` before it is returned.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data/address width.
- `LINE_WORDS`, 4: words per line, a power of two.
- `NUM_LINES`, 16: number of lines, a power of two.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `dcache_if` (slave modport) members:
  - `req_valid`  in  1  request strobe.
  - `write_en`  in  1  1 = store.
  - `req_addr`  in  32  byte address.
  - `write_data`  in  32  store value, right-aligned.
  - `size`  in  `MEM_SIZE_B`/`H`/`W`.
  - `sign`  in  1  sign-extend load.
  - `resp_valid`  out  1  completion pulse.
  - `resp_data`  out  32  load result.
  - `resp_ready`  out  1  can accept a request.
- `mem_req_valid`  out  1  memory request.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_write_en`  out  1  memory write.
- `mem_addr`  out  32  word-aligned address.
- `mem_wdata`  out  32  lane-positioned write data.
- `mem_wstrb`  out  4  byte strobes.
- `mem_resp_valid`  in  1  read data valid, or write ack.
- `mem_resp_data`  in  32  read word.

## Operation
- **Address split:** offset = `addr[log2(LINE_WORDS)+1:0]`; index = next `log2(NUM_LINES)` bits; tag = the remaining upper bits.
- **Storage:** valid bit per line (reset to 0), tag array, data array. Tag and data arrays are not reset.
- **States:**
  - **IDLE:** `resp_ready`=1. On `req_valid`, capture `addr`/`write_en`/`write_data`/`size`/`sign`, then go to LOOKUP. `req_valid` in any other state is ignored.
  - **LOOKUP:** one cycle; hit = valid[index] && tag match.
    - Load hit: go to RESP.
    - Load miss: set fill counter to 0, go to FILL_REQ.
    - Store: on hit, merge strobed bytes into the line; go to WRITE_REQ.
  - **FILL_REQ:** assert `mem_req_valid`, `mem_write_en`=0, `mem_addr` = line base + 4·count. Hold until `mem_req_ready`, then go to FILL_WAIT.
  - **FILL_WAIT:** on `mem_resp_valid`, write the word into the line.
    - If not the last word: increment count, go to FILL_REQ.
    - Last word: set tag, set valid, go to RESP.
  - **WRITE_REQ:** assert `mem_req_valid`, `mem_write_en`=1, aligned address, `mem_wdata`, `mem_wstrb`. On `mem_req_ready`, go to WRITE_WAIT.
  - **WRITE_WAIT:** on `mem_resp_valid`, go to RESP.
  - **RESP:** `resp_valid`=1 for exactly one cycle, then IDLE.
- **Lane rules:**
  - W ignores `addr[1:0]`.
  - H uses `addr[1]`; `addr[0]` is ignored.
  - B uses `addr[1:0]`.
- **Store data:** `write_data[7:0]` or `[15:0]` is replicated into the selected lane; strobes are 0001<<a, 0011<<(2·a1), or 1111, where a = `addr[1:0]` and a1 = `addr[1]`.
- **Load data:** the selected lane is zero- or sign-extended per `sign`. `resp_data` is registered and holds its value until the next RESP. For stores, `resp_data` = 0.
- Store miss does not allocate and does not fill.

## Timing
- **Reset values:**
  - `resp_valid`=0, `resp_data`=0, `resp_ready`=1.
  - `mem_req_valid`=0, `mem_write_en`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0.
  - State = IDLE, all valid bits = 0.
- **Latency:** with the request presented in cycle N, `resp_ready`=0 from N+1 until `resp_valid` has fallen.
  - Load hit: `resp_valid` in cycle N+2.
  - Load miss: one cycle after the last fill response.
  - Store: one cycle after the write ack.
- One memory transaction is outstanding at a time. `mem_*` outputs are stable while `mem_req_valid` && !`mem_req_ready`.
- `mem_resp_valid` outside FILL_WAIT/WRITE_WAIT is ignored. This includes a late response arriving after reset.
- Reset mid-operation: immediate return to reset values. A partially filled line stays invalid.
- Simultaneous `req_valid` and `resp_valid` cannot occur, because `resp_ready`=0 in RESP.

## Test plan
1. **Reset, then load-word miss:** `lw` at 0x100; memory returns 0x80FF0011, 0x22, 0x33, 0x44.
   - Required: four reads at 0x100, 0x104, 0x108, 0x10C, then `resp_data`=0x80FF0011.
2. **Load hits on the filled line:**
   - `lb` at 0x103 returns 0xFFFFFF80; `lbu` at 0x103 returns 0x00000080.
   - `lh` at 0x102 returns 0xFFFF80FF.
   - Each hit gives `resp_valid` at N+2 with no `mem_req_valid`.
3. **Store halfword, hit:** `sh` 0xBEEF at 0x102.
   - Required: memory write at 0x100, `mem_wstrb`=1100, `mem_wdata`=0xBEEFBEEF; the ack gives `resp_valid`.
   - Then `lw` at 0x100 hits and returns 0xBEEF0011.
4. **Store miss:** `sw` 0x12345678 at 0x340.
   - Required: one memory write, no fill.
   - Then `lw` at 0x340 misses and fills from 0x340.
5. **Conflict eviction:** with 0x100 resident, `lw` at 0x200 (same index 0) refills.
   - Required: a following `lw` at 0x100 misses again and refetches 4 words.
6. **Reset during fill:** `rst_n` pulsed low during FILL_WAIT of word 2.
   - Required: outputs return to reset values; a late `mem_resp_valid` is ignored; `lw` at the same address misses.

Source files
------------

// File: rtl/dcache_if.sv
// Load/store request channel between the control unit and the data cache,
// plus the access-size encoding shared by both ends.
package dcache_pkg;
    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'd0,
        MEM_SIZE_H = 2'd1,
        MEM_SIZE_W = 2'd2
    } mem_size_t;
endpackage

interface dcache_if #(parameter int DATA_WIDTH = 32);
    import dcache_pkg::*;
    logic                  req_valid;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] write_data;
    mem_size_t             size;
    logic                  sign;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_ready;

    // req_valid is taken only while resp_ready=1; resp_valid is a one-cycle
    // completion pulse and resp_data holds until the next completion.
    modport slave  (input  req_valid, write_en, req_addr, write_data, size, sign,
                    output resp_valid, resp_data, resp_ready);
    modport master (output req_valid, write_en, req_addr, write_data, size, sign,
                    input  resp_valid, resp_data, resp_ready);
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with word-wide
// line refill from backing memory.
module dcache
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dcache_if.slave                 bus,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_write_en,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data,
    output logic [2:0]              o_dbg_state
);
    localparam int WO_W  = $clog2(LINE_WORDS);
    localparam int OFF_W = WO_W + 2;
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = DATA_WIDTH - OFF_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, FILL_REQ, FILL_WAIT, WRITE_REQ, WRITE_WAIT, RESP
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_addr, r_wdata;
    logic                    r_we, r_sign;
    mem_size_t               r_size;
    logic [WO_W-1:0]         r_cnt;
    logic [NUM_LINES-1:0]    r_valid;
    logic [TAG_W-1:0]        r_tags [NUM_LINES];
    logic [DATA_WIDTH-1:0]   r_data [NUM_LINES][LINE_WORDS];
    logic                    r_resp_valid, r_resp_ready;
    logic [DATA_WIDTH-1:0]   r_resp_data;
    logic                    r_mem_req_valid, r_mem_write_en;
    logic [DATA_WIDTH-1:0]   r_mem_addr, r_mem_wdata;
    logic [DATA_WIDTH/8-1:0] r_mem_wstrb;

    logic [IDX_W-1:0]        w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic [WO_W-1:0]         w_wo, w_cnt_nxt;
    logic [1:0]              w_a;
    logic                    w_hit, w_fill_we;
    logic [DATA_WIDTH/8-1:0] w_wstrb;
    logic [DATA_WIDTH-1:0]   w_wdata, w_line_word, w_load;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;

    assign w_a       = r_addr[1:0];
    assign w_wo      = r_addr[2 +: WO_W];
    assign w_idx     = r_addr[OFF_W +: IDX_W];
    assign w_tag     = r_addr[DATA_WIDTH-1 -: TAG_W];
    assign w_hit     = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
    assign w_cnt_nxt = r_cnt + WO_W'(1);
    assign w_fill_we = (r_state == FILL_WAIT) && mem_resp_valid;

    // On the last refill beat the requested word may still be on the memory bus.
    assign w_line_word = (w_fill_we && r_cnt == w_wo) ? mem_resp_data : r_data[w_idx][w_wo];
    assign w_byte      = w_line_word[{w_a, 3'b000} +: 8];
    assign w_half      = w_line_word[{w_a[1], 4'b0000} +: 16];

    always_comb begin
        w_wstrb = '1;
        w_wdata = r_wdata;
        w_load  = w_line_word;
        case (r_size)
            MEM_SIZE_B: begin
                w_wstrb = 4'b0001 << w_a;
                w_wdata = {4{r_wdata[7:0]}};
                w_load  = r_sign ? {{(DATA_WIDTH-8){w_byte[7]}}, w_byte}
                                 : {{(DATA_WIDTH-8){1'b0}}, w_byte};
            end
            MEM_SIZE_H: begin
                w_wstrb = 4'b0011 << {w_a[1], 1'b0};
                w_wdata = {2{r_wdata[15:0]}};
                w_load  = r_sign ? {{(DATA_WIDTH-16){w_half[15]}}, w_half}
                                 : {{(DATA_WIDTH-16){1'b0}}, w_half};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_we            <= 1'b0;
            r_sign          <= 1'b0;
            r_size          <= MEM_SIZE_W;
            r_cnt           <= '0;
            r_valid         <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_ready    <= 1'b1;
            r_resp_data     <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_write_en  <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_mem_wstrb     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_addr       <= bus.req_addr;
                    r_wdata      <= bus.write_data;
                    r_we         <= bus.write_en;
                    r_size       <= bus.size;
                    r_sign       <= bus.sign;
                    r_resp_ready <= 1'b0;
                    r_state      <= LOOKUP;
                end
                LOOKUP: begin
                    if (r_we) begin
                        r_mem_req_valid <= 1'b1;
                        r_mem_write_en  <= 1'b1;
                        r_mem_addr      <= {r_addr[DATA_WIDTH-1:2], 2'b00};
                        r_mem_wdata     <= w_wdata;
                        r_mem_wstrb     <= w_wstrb;
                        r_state         <= WRITE_REQ;
                    end else if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_load;
                        r_state      <= RESP;
                    end else begin
                        r_cnt           <= '0;
                        r_mem_req_valid <= 1'b1;
                        r_mem_write_en  <= 1'b0;
                        r_mem_addr      <= {r_addr[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        r_mem_wstrb     <= '0;
                        r_state         <= FILL_REQ;
                    end
                end
                FILL_REQ: if (mem_req_ready) begin
                    r_mem_req_valid <= 1'b0;
                    r_state         <= FILL_WAIT;
                end
                FILL_WAIT: if (mem_resp_valid) begin
                    if (&r_cnt) begin
                        r_valid[w_idx] <= 1'b1;
                        r_resp_valid   <= 1'b1;
                        r_resp_data    <= w_load;
                        r_state        <= RESP;
                    end else begin
                        r_cnt           <= w_cnt_nxt;
                        r_mem_req_valid <= 1'b1;
                        r_mem_addr      <= {r_addr[DATA_WIDTH-1:OFF_W], w_cnt_nxt, 2'b00};
                        r_state         <= FILL_REQ;
                    end
                end
                WRITE_REQ: if (mem_req_ready) begin
                    r_mem_req_valid <= 1'b0;
                    r_state         <= WRITE_WAIT;
                end
                WRITE_WAIT: if (mem_resp_valid) begin
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= '0;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_resp_ready <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; only the valid bits above gate their use.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[w_idx][r_cnt] <= mem_resp_data;
            if (&r_cnt)
                r_tags[w_idx] <= w_tag;
        end
        if (r_state == LOOKUP && r_we && w_hit) begin
            for (int b = 0; b < DATA_WIDTH/8; b++)
                if (w_wstrb[b])
                    r_data[w_idx][w_wo][8*b +: 8] <= w_wdata[8*b +: 8];
        end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_ready = r_resp_ready;
    assign mem_req_valid  = r_mem_req_valid;
    assign mem_write_en   = r_mem_write_en;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign mem_wstrb      = r_mem_wstrb;
    assign o_dbg_state    = r_state;
endmodule
